// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter.
// Grants one of NUM_MASTERS requesters at a time. The grant rotates in
// round-robin order starting after the last requesting master served. An
// owner keeps the bus for a time slice of MAX_HOLD completed transfers, and
// the slice only ends on address-phase boundaries (IDLE/NONSEQ). A locked
// owner is never pre-empted. HMASTER and HMASTLOCK follow the grant by one
// completed transfer.
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [2:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] DEF_IDX    = 3'(DEFAULT_MASTER);
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_SAT   = 8'hFF;
  localparam logic [3:0] NUM_M_C    = 4'(NUM_MASTERS);

  // One-hot decode of a master index.
  function automatic logic [NUM_MASTERS-1:0] idx_onehot(input logic [2:0] idx);
    logic [NUM_MASTERS-1:0] oh;
    oh = {NUM_MASTERS{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      oh[i] = (3'(i) == idx);
    end
    return oh;
  endfunction

  logic [2:0]             gnt_idx_q, gnt_idx_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [2:0]             hmaster_q;
  logic                   hmastlock_q;

  logic                   addr_beat_s;
  logic                   count_beat_s;
  logic                   own_req_s;
  logic                   other_req_s;
  logic                   lock_hold_s;
  logic                   slice_done_s;
  logic                   slice_exp_s;
  logic                   rearb_s;
  logic                   renew_s;
  logic [NUM_MASTERS-1:0] cand_s;
  logic [NUM_MASTERS-1:0] rot_s;
  logic [3:0]             shift_s;
  logic [3:0]             sum_s;
  logic                   found_s;
  logic [2:0]             win_idx_s;

  // Classify the current beat: slice boundaries vs. counted transfers.
  always_comb begin
    addr_beat_s  = 1'b0;
    count_beat_s = 1'b0;
    case (HTRANS)
      TRANS_IDLE: begin
        addr_beat_s  = 1'b1;
        count_beat_s = 1'b0;
      end
      TRANS_BUSY: begin
        addr_beat_s  = 1'b0;
        count_beat_s = 1'b0;
      end
      TRANS_NONSEQ: begin
        addr_beat_s  = 1'b1;
        count_beat_s = 1'b1;
      end
      TRANS_SEQ: begin
        addr_beat_s  = 1'b0;
        count_beat_s = 1'b1;
      end
      default: begin
        addr_beat_s  = 1'b0;
        count_beat_s = 1'b0;
      end
    endcase
  end

  // Owner/other request qualifiers and the re-arbitration decision.
  // hgrant_q is always the one-hot of gnt_idx_q, so it masks the owner bit.
  always_comb begin
    own_req_s    = |(HBUSREQ & hgrant_q);
    other_req_s  = |(HBUSREQ & ~hgrant_q);
    lock_hold_s  = |(HLOCK & HBUSREQ & hgrant_q);
    slice_done_s = (hold_cnt_q >= MAX_HOLD_C) && addr_beat_s;
    slice_exp_s  = slice_done_s && other_req_s;
    rearb_s      = HREADY && !lock_hold_s && (!own_req_s || slice_exp_s);
    // Sole requester at a slice boundary: keep the bus, start a fresh slice.
    renew_s      = HREADY && !lock_hold_s && own_req_s && slice_done_s && !other_req_s;
  end

  // Round-robin search from rr_ptr+1 over the non-owner requesters.
  always_comb begin
    cand_s    = HBUSREQ & ~hgrant_q;
    shift_s   = {1'b0, rr_ptr_q} + 4'd1;
    rot_s     = NUM_MASTERS'({cand_s, cand_s} >> shift_s);
    found_s   = 1'b0;
    win_idx_s = gnt_idx_q;
    sum_s     = 4'd0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found_s && rot_s[j]) begin
        found_s   = 1'b1;
        sum_s     = shift_s + 4'(j);
        win_idx_s = (sum_s >= NUM_M_C) ? 3'(sum_s - NUM_M_C) : 3'(sum_s);
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Next grant, pointer and slice counter.
  always_comb begin
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (rearb_s) begin
      if (found_s) begin
        gnt_idx_d = win_idx_s;
        rr_ptr_d  = win_idx_s;
      end else if (own_req_s) begin
        // Owner is considered last: it keeps the bus, pointer unchanged.
        gnt_idx_d = gnt_idx_q;
      end else begin
        gnt_idx_d = DEF_IDX;
      end
    end else begin
      gnt_idx_d = gnt_idx_q;
    end

    if (gnt_idx_d != gnt_idx_q) begin
      hold_cnt_d = 8'd0;
    end else if (renew_s || (rearb_s && own_req_s)) begin
      hold_cnt_d = 8'd0;
    end else if (HREADY && count_beat_s && (hold_cnt_q != HOLD_SAT)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Arbiter state and registered bus outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_idx_q   <= DEF_IDX;
      rr_ptr_q    <= DEF_IDX;
      hold_cnt_q  <= 8'd0;
      hgrant_q    <= idx_onehot(DEF_IDX);
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      hgrant_q   <= idx_onehot(gnt_idx_d);
      if (HREADY) begin
        hmaster_q   <= gnt_idx_q;
        hmastlock_q <= |(HLOCK & hgrant_q);
      end else begin
        hmaster_q   <= hmaster_q;
        hmastlock_q <= hmastlock_q;
      end
    end
  end

  assign HGRANT    = hgrant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed + random bench for ahb_rr_arbiter with a reference model feeding
// an expected-value queue.
module tb_ahb_rr_arbiter;

  localparam int NM = 4;
  localparam int DM = 0;
  localparam int MH = 4;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [NM-1:0] HBUSREQ;
  logic [NM-1:0] HLOCK;
  logic [1:0]    HTRANS;
  logic          HREADY;
  logic [NM-1:0] HGRANT;
  logic [2:0]    HMASTER;
  logic          HMASTLOCK;

  ahb_rr_arbiter #(
    .NUM_MASTERS   (NM),
    .DEFAULT_MASTER(DM),
    .MAX_HOLD      (MH)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [NM-1:0] grant;
    logic [2:0]    master;
    logic          mlock;
  } exp_t;

  exp_t sb_q[$];
  int   chg_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_gnt;
  int   m_rr;
  int   m_hold;
  int   m_master;
  logic m_mlock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt    = DM;
    m_rr     = DM;
    m_hold   = 0;
    m_master = DM;
    m_mlock  = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle, predict the outputs after the edge, then compare.
  task automatic step(input logic [NM-1:0] req, input logic [NM-1:0] lck,
                      input logic [1:0] tr, input logic rdy, input string tag);
    exp_t       e;
    logic [1:0] g;
    bit         own, lockh, other, elig, done, rearb, found;
    int         nxt;
    @(negedge HCLK);
    HBUSREQ = req;
    HLOCK   = lck;
    HTRANS  = tr;
    HREADY  = rdy;
    g     = m_gnt[1:0];
    own   = req[g];
    lockh = lck[g] && own;
    other = (req & ~(4'b0001 << g)) != 4'b0000;
    elig  = (tr == T_IDLE) || (tr == T_NONSEQ);
    done  = (m_hold >= MH) && elig;
    rearb = rdy && !lockh && (!own || (done && other));
    nxt   = m_gnt;
    found = 1'b0;
    if (rearb) begin
      for (int k = 1; k <= NM; k++) begin
        int c;
        c = (m_rr + k) % NM;
        if (!found && (c != m_gnt) && req[c[1:0]]) begin
          found = 1'b1;
          nxt   = c;
        end
      end
      if (found) m_rr = nxt;
      else if (!own) nxt = DM;
    end
    if (nxt != m_gnt) m_hold = 0;
    else if (rdy && !lockh && own && done && !other) m_hold = 0;
    else if (rdy && (tr == T_NONSEQ || tr == T_SEQ) && m_hold < 255) m_hold++;
    if (rdy) begin
      m_master = m_gnt;
      m_mlock  = lck[g];
    end
    m_gnt    = nxt;
    e.grant  = 4'b0001 << nxt;
    e.master = 3'(m_master);
    e.mlock  = m_mlock;
    sb_q.push_back(e);
    @(posedge HCLK);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".grant"},  32'(HGRANT),    32'(e.grant));
    chk({tag, ".master"}, 32'(HMASTER),   32'(e.master));
    chk({tag, ".mlock"},  32'(HMASTLOCK), 32'(e.mlock));
  endtask

  initial begin
    logic [NM-1:0] prev;
    int            exp_order[5];
    exp_order = '{1, 2, 3, 0, 1};

    HRESETn = 1'b0;
    HBUSREQ = 4'b0000;
    HLOCK   = 4'b0000;
    HTRANS  = T_IDLE;
    HREADY  = 1'b1;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk("reset.grant",  32'(HGRANT),    32'h1);
    chk("reset.master", 32'(HMASTER),   32'h0);
    chk("reset.mlock",  32'(HMASTLOCK), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Idle after reset: default master keeps the grant.
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 4'b0000, T_IDLE, 1'b1, "idle");
      chk("idle.grant_const", 32'(HGRANT), 32'h1);
      chk("idle.mlock_const", 32'(HMASTLOCK), 32'h0);
    end

    // Round-robin fairness with all masters requesting.
    prev = HGRANT;
    chg_q.delete();
    for (int i = 0; i < 26; i++) begin
      step(4'b1111, 4'b0000, T_NONSEQ, 1'b1, "rr");
      if (HGRANT !== prev) begin
        for (int b = 0; b < NM; b++) if (HGRANT[b]) chg_q.push_back(b);
      end
      prev = HGRANT;
    end
    chk("rr.changes", 32'(chg_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr.order", (i < chg_q.size()) ? 32'(chg_q[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    end

    // Wait states freeze the grant; release hands back to the default master.
    step(4'b0100, 4'b0000, T_NONSEQ, 1'b1, "ws.own2");
    chk("ws.own2_const", 32'(HGRANT), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'b0000, T_NONSEQ, 1'b0, "ws.wait");
      chk("ws.wait_const", 32'(HGRANT), 32'h4);
    end
    step(4'b0000, 4'b0000, T_IDLE, 1'b1, "ws.release");
    chk("ws.release_const", 32'(HGRANT), 32'h1);

    // Locked owner is never pre-empted.
    step(4'b0010, 4'b0000, T_NONSEQ, 1'b1, "lk.get1");
    chk("lk.get1_const", 32'(HGRANT), 32'h2);
    for (int i = 0; i < 10; i++) begin
      step(4'b1010, 4'b0010, T_NONSEQ, 1'b1, "lk.hold");
      chk("lk.hold_grant", 32'(HGRANT), 32'h2);
      chk("lk.hold_mlock", 32'(HMASTLOCK), 32'h1);
    end
    step(4'b1010, 4'b0000, T_NONSEQ, 1'b1, "lk.unlock");
    chk("lk.unlock_const", 32'(HGRANT), 32'h8);

    // Burst protection: expiry waits for an IDLE/NONSEQ beat with HREADY.
    step(4'b0001, 4'b0000, T_IDLE, 1'b1, "bp.get0");
    chk("bp.get0_const", 32'(HGRANT), 32'h1);
    step(4'b0101, 4'b0000, T_NONSEQ, 1'b1, "bp.first");
    chk("bp.first_const", 32'(HGRANT), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 4'b0000, T_SEQ, 1'b1, "bp.seq");
      chk("bp.seq_const", 32'(HGRANT), 32'h1);
    end
    step(4'b0101, 4'b0000, T_BUSY, 1'b1, "bp.busy");
    chk("bp.busy_const", 32'(HGRANT), 32'h1);
    step(4'b0101, 4'b0000, T_NONSEQ, 1'b0, "bp.wait");
    chk("bp.wait_const", 32'(HGRANT), 32'h1);
    step(4'b0101, 4'b0000, T_NONSEQ, 1'b1, "bp.move");
    chk("bp.move_const", 32'(HGRANT), 32'h4);

    // Sole requester keeps the bus across slices.
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, 4'b0000, T_NONSEQ, 1'b1, "sole");
      chk("sole.grant_const", 32'(HGRANT), 32'h4);
    end

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      logic [NM-1:0] rq, lk;
      rq = 4'($urandom_range(0, 15));
      lk = rq & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      step(rq, lk, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), "rand");
    end

    // Reset in the middle of a locked burst.
    for (int i = 0; i < 3; i++) step(4'b0010, 4'b0010, T_NONSEQ, 1'b1, "mr.lock");
    step(4'b0010, 4'b0010, T_SEQ, 1'b1, "mr.seq");
    chk("mr.pre_grant", 32'(HGRANT), 32'h2);
    chk("mr.pre_mlock", 32'(HMASTLOCK), 32'h1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("mr.async_grant",  32'(HGRANT),    32'h1);
    chk("mr.async_master", 32'(HMASTER),   32'h0);
    chk("mr.async_mlock",  32'(HMASTLOCK), 32'h0);
    model_reset();
    HBUSREQ = 4'b0000;
    HLOCK   = 4'b0000;
    HTRANS  = T_IDLE;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step(4'b0110, 4'b0000, T_IDLE, 1'b1, "mr.first");
    chk("mr.first_const", 32'(HGRANT), 32'h2);
    step(4'b0110, 4'b0000, T_NONSEQ, 1'b1, "mr.after");
    chk("mr.after_mlock", 32'(HMASTLOCK), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
